// File: rtl/avalon_irq_pkg.sv
// Shared constants and helpers for the Avalon-MM interrupt controller.
// Register addresses, ACTIVE layout and a priority helper.
package avalon_irq_pkg;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_RAW      = 3'd4;
    localparam logic [2:0] ADDR_COUNT    = 3'd5;
    localparam logic [2:0] ADDR_FORCE    = 3'd6;

    localparam int          ACTIVE_VALID_BIT = 15;
    localparam logic [15:0] COUNT_MAX        = 16'hFFFF;

    // Bit 0 is the highest priority, so the lowest set index wins.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/avalon_irq_ctrl_sync_edge.sv
// Per-source input synchronizer with previous-value register.
// Provides the synchronized level and a one-cycle rising-edge flag.
module irq_sync_edge
    import avalon_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq,
    output logic level,
    output logic rise
);

    logic irq_s;
    logic irq_d;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign irq_s = irq;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain <= '0;
                end else begin
                    chain[0] <= irq;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end
            assign irq_s = chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_d <= 1'b0;
        else          irq_d <= irq_s;
    end

    assign level = irq_s;
    assign rise  = irq_s & ~irq_d;

endmodule

// File: rtl/avalon_irq_ctrl.sv
// Interrupt controller: mask, level/edge pending, fixed priority id,
// interrupt counter and a 16-bit Avalon-MM register slave.
module avalon_irq_ctrl
    import avalon_irq_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out,
    output logic [3:0]         irq_id
);

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] act;
    logic [NUM_IRQ-1:0] wd;
    logic [15:0]        count_q;
    logic [15:0]        rd_mux;
    logic               wr;
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_edge;
    logic               wr_count;
    logic               wr_force;
    logic               unused_wd;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .reset_n(reset_n),
            .irq    (irq_in[g]),
            .level  (irq_s[g]),
            .rise   (rise[g])
        );
    end

    assign wr        = chipselect & ~write_n;
    assign wr_pend   = wr && (address == ADDR_PENDING);
    assign wr_mask   = wr && (address == ADDR_MASK);
    assign wr_edge   = wr && (address == ADDR_EDGE_SEL);
    assign wr_count  = wr && (address == ADDR_COUNT);
    assign wr_force  = wr && (address == ADDR_FORCE);
    assign wd        = writedata[NUM_IRQ-1:0];
    assign unused_wd = ^writedata;

    // A mode change discards the old pending state; otherwise set beats clear.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (wr_edge && (wd[i] != edge_q[i])) begin
                pend_d[i] = 1'b0;
            end else if (edge_q[i]) begin
                pend_d[i] = rise[i] | (wr_force & wd[i])
                          | (pend_q[i] & ~(wr_pend & wd[i]));
            end else begin
                pend_d[i] = irq_s[i];
            end
        end
    end

    assign act = pend_q & mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            edge_q  <= '0;
            pend_q  <= '0;
            irq_out <= 1'b0;
            irq_id  <= 4'd0;
            count_q <= 16'd0;
        end else begin
            pend_q  <= pend_d;
            irq_out <= |act;
            irq_id  <= lowest_set(16'(act));
            if (wr_mask) mask_q <= wd;
            if (wr_edge) edge_q <= wd;
            if (wr_count) begin
                count_q <= 16'd0;
            end else if ((|act) && !irq_out && (count_q != COUNT_MAX)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (address)
            ADDR_PENDING:  rd_mux = 16'(pend_q);
            ADDR_MASK:     rd_mux = 16'(mask_q);
            ADDR_EDGE_SEL: rd_mux = 16'(edge_q);
            ADDR_ACTIVE: begin
                rd_mux[ACTIVE_VALID_BIT] = irq_out;
                rd_mux[3:0]              = irq_id;
            end
            ADDR_RAW:      rd_mux = 16'(irq_s);
            ADDR_COUNT:    rd_mux = count_q;
            default:       rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= 16'd0;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_avalon_irq_ctrl.sv
// Directed bench for avalon_irq_ctrl (NUM_IRQ=8, SYNC_STAGES=2)
// with a queue scoreboard of expected values.
module tb_avalon_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq_out;
    logic [3:0]  irq_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    avalon_irq_ctrl #(
        .NUM_IRQ    (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq_in    (irq_in),
        .irq_out   (irq_out),
        .irq_id    (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic compare(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'd0;
    endtask

    task automatic rd(input logic [2:0] a, input string tag,
                      input logic [15:0] exp);
        push(tag, exp);
        address = a;
        tick();
        compare(readdata);
    endtask

    task automatic chk_irq(input string tag, input logic o, input logic [3:0] id);
        push({tag, "_out"}, {15'd0, o});
        compare({15'd0, irq_out});
        push({tag, "_id"}, {12'd0, id});
        compare({12'd0, irq_id});
    endtask

    task automatic pulse4();
        wr(3'd6, 16'h0010);
        wr(3'd0, 16'h0010);
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'd0;
        irq_in     = 8'd0;
        #12 reset_n = 1'b1;
        tick();

        chk_irq("reset", 1'b0, 4'd0);
        rd(3'd0, "reset_pending", 16'h0000);
        rd(3'd3, "reset_active", 16'h0000);
        rd(3'd5, "reset_count", 16'h0000);
        wr(3'd1, 16'hFFFF);
        rd(3'd1, "mask_width", 16'h00FF);
        wr(3'd1, 16'h0000);

        // edge source 3: exact latency from the input rise
        wr(3'd2, 16'h0008);
        wr(3'd1, 16'h0008);
        irq_in[3] = 1'b1;
        tick();
        irq_in[3] = 1'b0;
        tick();
        tick();
        chk_irq("edge3_early", 1'b0, 4'd0);
        tick();
        chk_irq("edge3", 1'b1, 4'd3);
        rd(3'd0, "edge3_pending", 16'h0008);
        wr(3'd0, 16'h0008);
        chk_irq("w1c_hold", 1'b1, 4'd3);
        tick();
        chk_irq("w1c_drop", 1'b0, 4'd0);
        rd(3'd5, "count_one", 16'h0001);

        // level source 0
        wr(3'd1, 16'h0001);
        irq_in[0] = 1'b1;
        repeat (4) tick();
        chk_irq("level0", 1'b1, 4'd0);
        wr(3'd0, 16'h0001);
        rd(3'd0, "level_w1c", 16'h0001);
        rd(3'd4, "raw", 16'h0001);
        irq_in[0] = 1'b0;
        repeat (3) tick();
        chk_irq("level_hold", 1'b1, 4'd0);
        tick();
        chk_irq("level_drop", 1'b0, 4'd0);
        rd(3'd5, "count_two", 16'h0002);

        // priority among 2, 5, 7
        wr(3'd2, 16'h00AC);
        wr(3'd6, 16'h00A4);
        wr(3'd1, 16'h00A4);
        tick();
        rd(3'd3, "active_2", 16'h8002);
        wr(3'd1, 16'h00A0);
        tick();
        rd(3'd3, "active_5", 16'h8005);
        rd(3'd0, "pending_257", 16'h00A4);
        rd(3'd6, "force_reads0", 16'h0000);
        rd(3'd7, "addr7_reads0", 16'h0000);
        wr(3'd0, 16'h00A4);
        wr(3'd1, 16'h0000);
        tick();
        tick();
        chk_irq("cleanup", 1'b0, 4'd0);

        // edge source 1: set wins over a concurrent W1C
        wr(3'd2, 16'h00AE);
        wr(3'd6, 16'h0002);
        irq_in[1] = 1'b1;
        tick();
        tick();
        wr(3'd0, 16'h0002);
        rd(3'd0, "set_wins", 16'h0002);
        wr(3'd0, 16'h0002);
        rd(3'd0, "w1c_plain", 16'h0000);
        irq_in[1] = 1'b0;

        // FORCE in edge mode and in level mode
        wr(3'd2, 16'h00BE);
        wr(3'd1, 16'h0010);
        wr(3'd6, 16'h0010);
        tick();
        chk_irq("force_edge", 1'b1, 4'd4);
        wr(3'd0, 16'h0010);
        tick();
        chk_irq("force_clr", 1'b0, 4'd0);
        wr(3'd2, 16'h00AE);
        wr(3'd6, 16'h0010);
        tick();
        tick();
        chk_irq("force_level", 1'b0, 4'd0);
        rd(3'd0, "force_level_pend", 16'h0000);

        // counter saturation from a preloaded value
        wr(3'd2, 16'h00BE);
        #2;
        force dut.count_q = 16'hFFFC;
        #1;
        release dut.count_q;
        tick();
        pulse4();
        pulse4();
        rd(3'd5, "count_fffe", 16'hFFFE);
        pulse4();
        pulse4();
        pulse4();
        rd(3'd5, "count_sat", 16'hFFFF);

        // clear beats a concurrent increment
        wr(3'd6, 16'h0010);
        wr(3'd5, 16'h1234);
        chk_irq("clr_race", 1'b1, 4'd4);
        rd(3'd5, "count_clr", 16'h0000);

        // asynchronous reset while interrupting
        #2 reset_n = 1'b0;
        #1;
        chk_irq("async_rst", 1'b0, 4'd0);
        tick();
        tick();
        reset_n = 1'b1;
        rd(3'd0, "rst_pending", 16'h0000);
        rd(3'd1, "rst_mask", 16'h0000);
        rd(3'd2, "rst_edge", 16'h0000);
        rd(3'd3, "rst_active", 16'h0000);
        rd(3'd5, "rst_count", 16'h0000);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_left observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
